// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-side responder for CPU data accesses in the MMIO window.
//   It decodes load and store requests from the pipeline. It serves the UART
//   status and data registers, a cycle counter and a retired-instruction
//   counter.
//   Read data is registered with one cycle of latency, the same as the data
//   BRAM. The writeback mux can therefore treat it exactly like BRAM load data.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   addr            byte address from the MEM stage; [31:28] selects the block,
//                   [7:0] is the register offset
//   wdata, byte_en  store data (lane-aligned) and byte mask
//   wr_en, rd_en    store / load request this cycle
//   inst_retire     one pulse per committed instruction
//   mmio_hit        combinational window decode (0 while in reset)
//   rdata           registered read data, valid the cycle after rd_en
//   uart_tx_*       valid/ready byte stream towards the transmitter
//   uart_rx_*       valid/ready byte stream from the receiver; ready is a
//                   combinational pulse raised by a load of the data register
module mmio_responder #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [3:0]  MMIO_TAG  = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        inst_retire,
  output logic        mmio_hit,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // Register offsets
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]          rdata_q,   rdata_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_vld_q,  tx_vld_d;
  logic [CNT_WIDTH-1:0] cyc_q,     cyc_d;
  logic [CNT_WIDTH-1:0] ins_q,     ins_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [7:0] off;
  logic       rd_hit, wr_hit;
  logic       tx_store, cnt_clear;

  assign off      = addr[7:0];
  // Gated by reset so that nothing downstream acts on a stale bus during reset.
  assign mmio_hit = !rst && (addr[31:28] == MMIO_TAG);
  assign rd_hit   = rd_en && mmio_hit;
  assign wr_hit   = wr_en && mmio_hit;

  // A TX store is only taken when the holding register is empty. Software
  // polls status bit0 first, so a store that finds it full is dropped.
  assign tx_store  = wr_hit && (off == OFF_TXDATA) && byte_en[0] && !tx_vld_q;
  assign cnt_clear = wr_hit && (off == OFF_CLEAR);

  // The RX byte is consumed on the same edge that rdata captures it.
  assign uart_rx_ready = rd_hit && (off == OFF_RXDATA) && uart_rx_valid;

  // Only the low address byte and the low store byte carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8], byte_en[3:1]};

  // ---------------------------------------------------------------------------
  // Read mux (always samples the pre-edge state, so a read that coincides
  // with a write or a counter clear returns the old value)
  // ---------------------------------------------------------------------------
  logic [31:0] rd_sel;

  always_comb begin
    rd_sel = 32'h0;
    unique case (off)
      OFF_STATUS: rd_sel = {30'b0, uart_rx_valid, ~tx_vld_q};
      OFF_RXDATA: rd_sel = {24'b0, uart_rx_data};
      OFF_CYCLE:  rd_sel = 32'(cyc_q);
      OFF_INSTR:  rd_sel = 32'(ins_q);
      default:    rd_sel = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_hit) rdata_d = rd_sel;
  end

  // ---------------------------------------------------------------------------
  // TX holding register
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_vld_d  = tx_vld_q;
    tx_data_d = tx_data_q;
    if (tx_store) begin
      tx_vld_d  = 1'b1;
      tx_data_d = wdata[7:0];
    end else if (tx_vld_q && uart_tx_ready) begin
      tx_vld_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters; a clear takes priority over the increment
  // ---------------------------------------------------------------------------
  always_comb begin
    cyc_d = cyc_q + CNT_ONE;
    ins_d = inst_retire ? ins_q + CNT_ONE : ins_q;
    if (cnt_clear) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      rdata_q   <= rdata_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign rdata         = rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_vld_q;

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic        wr_en, rd_en, inst_retire;
  logic        uart_tx_ready, uart_rx_valid;
  logic [7:0]  uart_rx_data;

  logic        mmio_hit, uart_tx_valid, uart_rx_ready;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;

  // narrow-counter instance: same stimulus, 4-bit counters to exercise wrap
  logic        n_hit, n_txv, n_rxr;
  logic [31:0] n_rdata;
  logic [7:0]  n_txd;

  mmio_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .wr_en(wr_en), .rd_en(rd_en), .inst_retire(inst_retire),
    .mmio_hit(mmio_hit), .rdata(rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  mmio_responder #(.CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .wr_en(wr_en), .rd_en(rd_en), .inst_retire(inst_retire),
    .mmio_hit(n_hit), .rdata(n_rdata),
    .uart_tx_data(n_txd), .uart_tx_valid(n_txv),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(n_rxr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: counts of elapsed cycles / retirements, a pending-byte flag
  int unsigned m_cyc, m_ins;
  bit          m_txv;
  logic [7:0]  m_txd;
  logic [31:0] m_rd, m_rdn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic ret, input logic txr, input logic rxv, input logic [7:0] rxd);
    bit         hit, rxr;
    logic [7:0] off;
    rst = r; rd_en = rd; wr_en = wr; addr = a; wdata = wd; byte_en = be;
    inst_retire = ret; uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd;
    @(negedge clk);
    off = a[7:0];
    hit = !r && (a[31:28] == 4'h8);
    rxr = rd && hit && off == 8'h04 && rxv;
    chk("mmio_hit", {31'b0, mmio_hit}, {31'b0, hit});
    chk("rx_ready", {31'b0, uart_rx_ready}, {31'b0, rxr});
    chk("n_rx_ready", {31'b0, n_rxr}, {31'b0, rxr});
    if (r) begin
      m_rd = 0; m_rdn = 0; m_txv = 0; m_txd = 0; m_cyc = 0; m_ins = 0;
    end else begin
      if (rd && hit) begin
        case (off)
          8'h00:   begin m_rd = {30'b0, rxv, ~m_txv}; m_rdn = m_rd; end
          8'h04:   begin m_rd = {24'b0, rxd};         m_rdn = m_rd; end
          8'h10:   begin m_rd = m_cyc; m_rdn = m_cyc % 16; end
          8'h14:   begin m_rd = m_ins; m_rdn = m_ins % 16; end
          default: begin m_rd = 0; m_rdn = 0; end
        endcase
      end
      if (wr && hit && off == 8'h08 && be[0] && !m_txv) begin
        m_txv = 1; m_txd = wd[7:0];
      end else if (m_txv && txr) begin
        m_txv = 0;
      end
      if (wr && hit && off == 8'h18) begin
        m_cyc = 0; m_ins = 0;
      end else begin
        m_cyc = m_cyc + 1;
        if (ret) m_ins = m_ins + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("rdata", rdata, m_rd);
    chk("n_rdata", n_rdata, m_rdn);
    chk("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_txv});
    if (m_txv) chk("tx_data", {24'b0, uart_tx_data}, {24'b0, m_txd});
    else if (r) chk("tx_data_rst", {24'b0, uart_tx_data}, 32'h0);
  endtask

  task automatic idle(input logic txr);
    cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, txr, 0, 8'h00);
  endtask

  task automatic rd_at(input logic [31:0] a);
    cyc(0, 1, 0, a, 32'h0, 4'h0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    // reset for 3 cycles with a hitting address on the bus
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 32'h8000_0004, 32'h55, 4'hF, 1, 0, 1, 8'hAA);

    // cycle counter: 10 cycles after release it reads 10
    for (int i = 0; i < 10; i++) idle(0);
    rd_at(32'h8000_0010);
    chk("cycle_at_10", rdata, 32'd10);

    // TX: store 0x41 while transmitter stalls, second store dropped, then drain
    cyc(0, 0, 1, 32'h8000_0008, 32'h41, 4'h1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) idle(0);
    cyc(0, 0, 1, 32'h8000_0008, 32'h42, 4'h1, 0, 0, 0, 8'h00);
    idle(0);
    chk("tx_held", {24'b0, uart_tx_data}, 32'h41);
    rd_at(32'h8000_0000);
    chk("status_full", rdata, 32'h0);
    idle(1);
    chk("tx_drained", {31'b0, uart_tx_valid}, 32'h0);
    // byte_en[0] clear: not accepted
    cyc(0, 0, 1, 32'h8000_0008, 32'h43, 4'hE, 0, 0, 0, 8'h00);

    // RX: consume 0x5A
    cyc(0, 1, 0, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 1, 8'h5A);
    chk("rx_byte", rdata, 32'h5A);
    cyc(0, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 1, 8'h5A);
    chk("status_rx", rdata, 32'h3);

    // retire 7, clear, then instr counter 0 then 1; cycle counter restarts
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 8'h00);
    rd_at(32'h8000_0014);
    chk("instr_7", rdata, 32'd7);
    cyc(0, 0, 1, 32'h8000_0018, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 8'h00);
    rd_at(32'h8000_0014);
    chk("instr_cleared", rdata, 32'd0);
    cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 8'h00);
    rd_at(32'h8000_0014);
    chk("instr_1", rdata, 32'd1);
    rd_at(32'h8000_0010);
    chk("cycle_restart", rdata, 32'd3);

    // narrow counter wrap, unmapped offset, and a miss leaving rdata alone
    for (int i = 0; i < 20; i++) rd_at(32'h8000_0010);
    rd_at(32'h8000_0020);
    chk("unmapped_zero", rdata, 32'h0);
    rd_at(32'h8000_0014);
    cyc(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 8'h00);
    chk("miss_holds", rdata, 32'd1);

    // reset mid-operation with a byte pending
    cyc(0, 0, 1, 32'h8000_0008, 32'h77, 4'h1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 1, 8'h11);
    chk("rst_drop_tx", {31'b0, uart_tx_valid}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0]  offs [8];
      logic [31:0] a;
      logic        r, rd, wr;
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h0C};
      a = {4'h8, 20'($urandom), offs[$urandom_range(0, 7)]};
      if ($urandom_range(0, 5) == 0) a[31:28] = 4'($urandom_range(0, 7));
      r  = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 1) == 0);
      wr = ($urandom_range(0, 3) == 0);
      if (wr && a[7:0] == 8'h18 && $urandom_range(0, 3) != 0) wr = 0;
      cyc(r, rd, wr, a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
